tdm_mux8_tx: RTL and testbench

// - Transmit end of the 8-channel time-division link; the far end is the 8-way data distributor.
// - Latches an 8-bit parallel word and sends it one bit per slot on a single data line.
// - Drives the 3-bit channel select {oA,oB,oC} alongside each bit so the distributor can route it.
// - Framing and handshake signals let an upstream producer stream words back to back.

---
 rtl/tdm_pkg.sv | 29 ++
 rtl/tdm_mux8_tx_if.sv | 28 ++
 rtl/tdm_slot_counter.sv | 54 +++++
 rtl/tdm_mux8_tx.sv | 125 ++++++++++++
 tb/tb_tdm_mux8_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM link.
// Used by both the transmit end and the far-end distributor.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } tdmState_t;

  localparam int N_SLOTS = 8;
  localparam int SLOT_W = 3;
  localparam logic IDLE_BIT = 1'b1;

  // Select bus ordering: {A,B,C} = S2..S0
  localparam int SEL_A = 2;
  localparam int SEL_B = 1;
  localparam int SEL_C = 0;

  function automatic logic [SLOT_W-1:0] bitIndex(
    input logic [SLOT_W-1:0] slot,
    input bit lsbFirst
  );
    logic [SLOT_W-1:0] last;
    last = SLOT_W'(N_SLOTS - 1);
    return lsbFirst ? slot : last - slot;
  endfunction

endpackage

// File: rtl/tdm_mux8_tx_if.sv
// Producer handshake plus serial link outputs.
// master = producer/observer side, slave = transmitter.
interface tdm_mux8_tx_if;

  logic [7:0] iData;
  logic       iValid;
  logic       oReady;
  logic       oBit;
  logic       oA;
  logic       oB;
  logic       oC;
  logic       oFrame;
  logic       oBusy;
  logic       oDone;

  modport master (
    output iData, iValid,
    input  oReady, oBit, oA, oB, oC,
    input  oFrame, oBusy, oDone
  );

  modport slave (
    input  iData, iValid,
    output oReady, oBit, oA, oB, oC,
    output oFrame, oBusy, oDone
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Hold counter plus 3-bit slot counter.
// slotNext is exposed so the top can register outputs in step.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  output logic [SLOT_W-1:0] slot,
  output logic [SLOT_W-1:0] slotNext,
  output logic              lastSlotDone
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_SLOTS - 1);

  logic [3:0] hold;
  logic [3:0] holdNext;
  logic       holdWrap;

  assign holdWrap = (hold == HOLD_LAST);

  always_comb begin
    holdNext     = hold;
    slotNext     = slot;
    lastSlotDone = 1'b0;
    if (clear) begin
      holdNext = '0;
      slotNext = '0;
    end else if (enable) begin
      if (holdWrap) begin
        holdNext     = '0;
        slotNext     = slot + 3'd1;
        lastSlotDone = (slot == SLOT_LAST);
      end else begin
        holdNext = hold + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      slot <= '0;
    end else begin
      hold <= holdNext;
      slot <= slotNext;
    end
  end

endmodule

// File: rtl/tdm_mux8_tx.sv
// TDM transmit end: latch a byte, send one bit per slot
// with its channel select, framing and handshake.
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int HOLD      = 1,
  parameter bit LSB_FIRST = 1
) (
  input logic          clk,
  input logic          rst_n,
  tdm_mux8_tx_if.slave link
);

  if (HOLD < 1 || HOLD > 15) begin : gHoldCheck
    $error("tdm_mux8_tx: HOLD must be 1..15");
  end

  tdmState_t         state;
  tdmState_t         stateNext;
  logic [7:0]        shadow;
  logic [7:0]        shadowNext;
  logic              accept;
  logic              clear;
  logic              enable;
  logic              lastSlotDone;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slotNext;

  logic              readyQ, readyD;
  logic              bitQ, bitD;
  logic              frameQ, frameD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic [SLOT_W-1:0] selQ, selD;

  tdm_slot_counter #(
    .HOLD(HOLD)
  ) uCounter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .enable       (enable),
    .slot         (slot),
    .slotNext     (slotNext),
    .lastSlotDone (lastSlotDone)
  );

  assign accept = link.iValid && readyQ;

  always_comb begin
    stateNext  = state;
    shadowNext = shadow;
    clear      = 1'b0;
    enable     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext  = SEND;
          clear      = 1'b1;
          shadowNext = link.iData;
        end
      end
      SEND: begin
        enable = 1'b1;
        if (lastSlotDone) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
        if (accept) begin
          stateNext  = SEND;
          clear      = 1'b1;
          shadowNext = link.iData;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are computed from next-state so they land in step with it
  always_comb begin
    readyD = (stateNext != SEND);
    busyD  = (stateNext == SEND);
    doneD  = (stateNext == DONE);
    bitD   = IDLE_BIT;
    selD   = '0;
    frameD = 1'b0;
    if (busyD) begin
      bitD   = shadowNext[bitIndex(slotNext, LSB_FIRST)];
      selD   = slotNext;
      frameD = (slotNext == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= '0;
      readyQ <= 1'b1;
      bitQ   <= IDLE_BIT;
      selQ   <= '0;
      frameQ <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      shadow <= shadowNext;
      readyQ <= readyD;
      bitQ   <= bitD;
      selQ   <= selD;
      frameQ <= frameD;
      busyQ  <= busyD;
      doneQ  <= doneD;
    end
  end

  assign link.oReady = readyQ;
  assign link.oBit   = bitQ;
  assign link.oA     = selQ[SEL_A];
  assign link.oB     = selQ[SEL_B];
  assign link.oC     = selQ[SEL_C];
  assign link.oFrame = frameQ;
  assign link.oBusy  = busyQ;
  assign link.oDone  = doneQ;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Directed bench for tdm_mux8_tx.
// Observed vector: {bit, A,B,C, frame, busy, ready, done}.
module tb_tdm_mux8_tx;

  logic clk = 1'b0;
  logic rstA = 1'b0;
  logic rstB = 1'b0;

  always #5 clk = ~clk;

  tdm_mux8_tx_if ifA ();
  tdm_mux8_tx_if ifB ();

  tdm_mux8_tx #(
    .HOLD(1),
    .LSB_FIRST(1)
  ) dutA (
    .clk   (clk),
    .rst_n (rstA),
    .link  (ifA.slave)
  );

  tdm_mux8_tx #(
    .HOLD(3),
    .LSB_FIRST(0)
  ) dutB (
    .clk   (clk),
    .rst_n (rstB),
    .link  (ifB.slave)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] IDLE_V = 8'b1_000_0_0_1_0;
  localparam logic [7:0] DONE_V = 8'b1_000_0_0_1_1;

  logic [7:0] obsA;
  logic [7:0] obsB;

  assign obsA = {ifA.oBit, ifA.oA, ifA.oB, ifA.oC,
                 ifA.oFrame, ifA.oBusy, ifA.oReady, ifA.oDone};
  assign obsB = {ifB.oBit, ifB.oA, ifB.oB, ifB.oC,
                 ifB.oFrame, ifB.oBusy, ifB.oReady, ifB.oDone};

  task automatic test_reset();
    ifA.iData  = 8'h00;
    ifA.iValid = 1'b0;
    ifB.iData  = 8'h00;
    ifB.iValid = 1'b0;
    rstA = 1'b0;
    rstB = 1'b0;
    #12;
    checks++;
    if (obsA !== IDLE_V) begin
      errors++;
      $display("FAIL reset_A got %b want %b", obsA, IDLE_V);
    end
    checks++;
    if (obsB !== IDLE_V) begin
      errors++;
      $display("FAIL reset_B got %b want %b", obsB, IDLE_V);
    end
    @(negedge clk);
    rstA = 1'b1;
    rstB = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (obsA !== IDLE_V || obsB !== IDLE_V) begin
        errors++;
        $display("FAIL idle cyc %0d got %b/%b want %b",
                 c, obsA, obsB, IDLE_V);
      end
    end
  endtask

  task automatic test_single_word();
    logic [0:7] seq;
    logic [7:0] exp;
    logic [2:0] k3;
    seq = 8'b1010_0101;
    @(negedge clk);
    ifA.iData  = 8'hA5;
    ifA.iValid = 1'b1;
    @(negedge clk);
    ifA.iValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      k3  = 3'(k);
      exp = {seq[k], k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL single slot %0d got %b want %b",
                 k, obsA, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (obsA !== DONE_V) begin
      errors++;
      $display("FAIL single_done got %b want %b", obsA, DONE_V);
    end
    @(negedge clk);
    checks++;
    if (obsA !== IDLE_V) begin
      errors++;
      $display("FAIL single_idle got %b want %b", obsA, IDLE_V);
    end
  endtask

  task automatic test_hold3();
    logic [0:7] seq;
    logic [7:0] exp;
    logic [2:0] k3;
    int busy;
    seq  = 8'b0000_1111;
    busy = 0;
    @(negedge clk);
    ifB.iData  = 8'h0F;
    ifB.iValid = 1'b1;
    @(negedge clk);
    ifB.iValid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      k3  = 3'(c / 3);
      exp = {seq[c/3], k3, c < 3, 1'b1, 1'b0, 1'b0};
      if (ifB.oBusy === 1'b1) busy++;
      checks++;
      if (obsB !== exp) begin
        errors++;
        $display("FAIL hold3 cyc %0d got %b want %b",
                 c, obsB, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (obsB !== DONE_V) begin
      errors++;
      $display("FAIL hold3_done got %b want %b", obsB, DONE_V);
    end
    checks++;
    if (busy != 24) begin
      errors++;
      $display("FAIL hold3_busy got %0d want 24", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [2:0] k3;
    @(negedge clk);
    ifA.iData  = 8'hFF;
    ifA.iValid = 1'b1;
    @(negedge clk);
    ifA.iData = 8'h00;
    for (int k = 0; k < 8; k++) begin
      k3  = 3'(k);
      exp = {1'b1, k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL b2b_ff slot %0d got %b want %b",
                 k, obsA, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (obsA !== DONE_V) begin
      errors++;
      $display("FAIL b2b_done1 got %b want %b", obsA, DONE_V);
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      k3  = 3'(k);
      exp = {1'b0, k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL b2b_00 slot %0d got %b want %b",
                 k, obsA, exp);
      end
      ifA.iValid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (obsA !== DONE_V) begin
      errors++;
      $display("FAIL b2b_done2 got %b want %b", obsA, DONE_V);
    end
    @(negedge clk);
  endtask

  task automatic test_stability();
    logic [0:7] seq;
    logic [7:0] exp;
    logic [2:0] k3;
    seq = 8'b0011_1100;
    @(negedge clk);
    ifA.iData  = 8'h3C;
    ifA.iValid = 1'b1;
    @(negedge clk);
    ifA.iValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      k3  = 3'(k);
      exp = {seq[k], k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL stable slot %0d got %b want %b",
                 k, obsA, exp);
      end
      if (k == 2) ifA.iData = 8'hC3;
      @(negedge clk);
    end
    checks++;
    if (obsA !== DONE_V) begin
      errors++;
      $display("FAIL stable_done got %b want %b", obsA, DONE_V);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [0:7] seq;
    logic [7:0] exp;
    logic [2:0] k3;
    seq = 8'b1111_0000;
    @(negedge clk);
    ifA.iData  = 8'h0F;
    ifA.iValid = 1'b1;
    @(negedge clk);
    ifA.iValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      k3  = 3'(k);
      exp = {seq[k], k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL abort slot %0d got %b want %b",
                 k, obsA, exp);
      end
      if (k < 4) @(negedge clk);
    end
    #2 rstA = 1'b0;
    #1;
    checks++;
    if (obsA !== IDLE_V) begin
      errors++;
      $display("FAIL abort_async got %b want %b", obsA, IDLE_V);
    end
    @(negedge clk);
    rstA = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obsA !== IDLE_V) begin
        errors++;
        $display("FAIL abort_nodone cyc %0d got %b want %b",
                 c, obsA, IDLE_V);
      end
    end
    seq = 8'b1000_0001;
    ifA.iData  = 8'h81;
    ifA.iValid = 1'b1;
    @(negedge clk);
    ifA.iValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      k3  = 3'(k);
      exp = {seq[k], k3, k == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obsA !== exp) begin
        errors++;
        $display("FAIL after_rst slot %0d got %b want %b",
                 k, obsA, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (obsA !== DONE_V) begin
      errors++;
      $display("FAIL after_rst_done got %b want %b",
               obsA, DONE_V);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_hold3();
    test_back_to_back();
    test_stability();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
